// File: rtl/ifft_bfly_seq_if.sv
// Bus between the IFFT butterfly sequencer and the sample RAM / twiddle ROM / datapath:
// start/busy/done handshake, read-issue addresses and delayed write-back addresses.
interface ifft_bfly_seq_if #(
    parameter int AW = 5
);
    logic          start;
    logic          busy;
    logic          done;
    logic [2:0]    stage;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-2:0] tw_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ifft_bfly_seq.sv
// In-place radix-2 DIF butterfly sequencer for the IFFT core: one butterfly per cycle,
// flush gap between stages. Define IFFT_BFLY_SEQ_HOLD_EN to add the 'hold' stall input.
module ifft_bfly_seq #(
    parameter int N        = 32,
    parameter int LOG2N    = 5,
    parameter int AW       = 5,
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
`ifdef IFFT_BFLY_SEQ_HOLD_EN
    input  logic hold,
`endif
    ifft_bfly_seq_if.master bus
);
    localparam int HALF = N / 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-2:0] b_cnt;
    logic [2:0]    stage_cnt;
    logic [2:0]    fcnt;
    logic          frz;
    logic          held_q;
    logic          last_b;
    logic          last_stage;

    logic [AW-1:0] span;
    logic [AW-1:0] mask;
    logic [AW-1:0] bx;
    logic [AW-1:0] off;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-2:0] tw;

    // Index 0 is the read-issue register, index PIPE_LAT is the write-back strobe.
    logic [PIPE_LAT:0]         vld_pipe;
    logic [PIPE_LAT:0][AW-1:0] pa_pipe;
    logic [PIPE_LAT:0][AW-1:0] pb_pipe;
    logic [AW-2:0]             tw_q;
    logic [2:0]                stage_q;
    logic                      busy_q;
    logic                      done_q;

`ifdef IFFT_BFLY_SEQ_HOLD_EN
    // Hold never blocks start acceptance, so it only freezes outside IDLE.
    assign frz = hold && (state != IDLE);
`else
    assign frz = 1'b0;
`endif

    assign last_b     = (b_cnt == (AW-1)'(HALF - 1));
    assign last_stage = (stage_cnt == 3'(LOG2N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (!frz && last_b) state_nx = FLUSH;
            FLUSH:   if (!frz && fcnt == 3'd0) state_nx = last_stage ? DONE : RUN;
            DONE:    if (!frz) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_cnt     <= '0;
            stage_cnt <= '0;
            fcnt      <= '0;
        end else if (!frz) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_cnt     <= '0;
                        stage_cnt <= '0;
                    end
                end
                RUN: begin
                    b_cnt <= b_cnt + (AW-1)'(1);
                    if (last_b) fcnt <= 3'(PIPE_LAT - 1);
                end
                FLUSH: begin
                    if (fcnt != 3'd0) begin
                        fcnt <= fcnt - 3'd1;
                    end else if (!last_stage) begin
                        stage_cnt <= stage_cnt + 3'd1;
                        b_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Group bits of b move up one place to skip each group's bottom half; offset bits stay.
    always_comb begin
        span   = AW'(HALF >> stage_cnt);
        mask   = span - AW'(1);
        bx     = AW'(b_cnt);
        off    = bx & mask;
        addr_a = ((bx & ~mask) << 1) | off;
        addr_b = addr_a | span;
        tw     = (AW-1)'(off << stage_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            pa_pipe  <= '0;
            pb_pipe  <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
        end else if (!frz) begin
            vld_pipe[0] <= (state == RUN);
            stage_q     <= stage_cnt;
            if (state == RUN) begin
                pa_pipe[0] <= addr_a;
                pb_pipe[0] <= addr_b;
                tw_q       <= tw;
            end
            for (int i = 1; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pa_pipe[i]  <= pa_pipe[i-1];
                pb_pipe[i]  <= pb_pipe[i-1];
            end
        end
    end

    // held_q masks strobes of the frozen registers so a stalled entry is never seen twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            held_q <= frz;
            done_q <= (state == DONE) && !frz;
            busy_q <= (state == RUN) || (state == FLUSH) || ((state == DONE) && frz);
        end
    end

    assign bus.rd_en     = vld_pipe[0] & ~held_q;
    assign bus.rd_addr_a = pa_pipe[0];
    assign bus.rd_addr_b = pb_pipe[0];
    assign bus.tw_idx    = tw_q;
    assign bus.stage     = stage_q;
    assign bus.wr_en     = vld_pipe[PIPE_LAT] & ~held_q;
    assign bus.wr_addr_a = pa_pipe[PIPE_LAT];
    assign bus.wr_addr_b = pb_pipe[PIPE_LAT];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ifft_bfly_seq.sv
// Bench for ifft_bfly_seq: timing table for one transform, plus a scoreboard of issued
// butterflies against write-backs, mid-run reset, and (with the hold macro) stall runs.
module tb_ifft_bfly_seq;
    localparam int N        = 32;
    localparam int LOG2N    = 5;
    localparam int AW       = 5;
    localparam int PIPE_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef IFFT_BFLY_SEQ_HOLD_EN
    logic hold = 1'b0;
`endif

    ifft_bfly_seq_if #(.AW(AW)) bus ();

    ifft_bfly_seq #(.N(N), .LOG2N(LOG2N), .AW(AW), .PIPE_LAT(PIPE_LAT)) dut (
        .clk (clk),
        .rst (rst),
`ifdef IFFT_BFLY_SEQ_HOLD_EN
        .hold(hold),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; int tw; int st; } rd_t;
    typedef struct { int a; int b; int st; int cyc; } wr_t;
    // -1 in an expected field means "don't care"
    typedef struct {
        int cyc; int start;
        int rd; int ra; int rb; int tw; int st;
        int wr; int wa; int wb;
        int busy; int done;
    } vec_t;

    rd_t  exp_rd[$];
    wr_t  wq[$];
    vec_t tbl[16];

    int nvec = 0, nfail = 0;
    int edge_cnt = 0, base = 0;
    bit mon_on = 0, hold_run = 0;
    int wr_cnt = 0, done_cnt = 0, done_cyc = -1;
    rd_t e;
    wr_t w, t;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int cycle();
        return edge_cnt - base;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cycle(), act, exp);
        end
    endtask

    task automatic chk_dc(input string nm, input int act, input int exp);
        if (exp >= 0) chk(nm, act, exp);
    endtask

    // Reference issue order from the textbook div/mod form of the DIF address rule.
    task automatic begin_xfer();
        int span, grp, off;
        exp_rd.delete();
        wq.delete();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < N/2; b++) begin
                rd_t r;
                span = N >> (s + 1);
                grp  = b / span;
                off  = b % span;
                r.a  = grp * 2 * span + off;
                r.b  = r.a + span;
                r.tw = off << s;
                r.st = s;
                exp_rd.push_back(r);
            end
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        base = edge_cnt;
        mon_on = 1'b1;
    endtask

    task automatic end_xfer(input int exp_done);
        while (cycle() < exp_done + 2) @(negedge clk);
        mon_on = 1'b0;
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", wq.size(), 0);
        chk("wr_count", wr_cnt, N/2 * LOG2N);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, exp_done);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.rd_en) begin
                chk("rd_q_avail", int'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    chk("sb_rd_a", int'(bus.rd_addr_a), e.a);
                    chk("sb_rd_b", int'(bus.rd_addr_b), e.b);
                    chk("sb_tw", int'(bus.tw_idx), e.tw);
                    chk("sb_stage", int'(bus.stage), e.st);
                    t.a = e.a; t.b = e.b; t.st = e.st; t.cyc = cycle();
                    wq.push_back(t);
                end
            end
            if (bus.wr_en) begin
                wr_cnt++;
                chk("wr_q_avail", int'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("sb_wr_a", int'(bus.wr_addr_a), w.a);
                    chk("sb_wr_b", int'(bus.wr_addr_b), w.b);
                    if (!hold_run) chk("wr_latency", cycle() - w.cyc, PIPE_LAT);
                    if (bus.rd_en) chk("hazard_stage", int'(bus.stage), w.st);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cycle();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        //          cyc st  rd ra  rb  tw  st  wr wa  wb  busy done
        tbl[0]  = '{0,  0,  0, -1, -1, -1, -1, 0, -1, -1, 0, 0};
        tbl[1]  = '{1,  0,  1, 0,  16, 0,  0,  0, -1, -1, 1, 0};
        tbl[2]  = '{6,  0,  1, 5,  21, 5,  0,  1, 2,  18, 1, 0};
        tbl[3]  = '{10, 1,  1, 9,  25, 9,  0,  1, 6,  22, 1, 0};
        tbl[4]  = '{16, 0,  1, 15, 31, 15, 0,  1, 12, 28, 1, 0};
        tbl[5]  = '{17, 0,  0, -1, -1, -1, -1, 1, 13, 29, 1, 0};
        tbl[6]  = '{19, 0,  0, -1, -1, -1, -1, 1, 15, 31, 1, 0};
        tbl[7]  = '{20, 0,  1, 0,  8,  0,  1,  0, -1, -1, 1, 0};
        tbl[8]  = '{29, 0,  1, 17, 25, 2,  1,  1, 6,  14, 1, 0};
        tbl[9]  = '{44, 0,  1, 9,  13, 4,  2,  1, 2,  6,  1, 0};
        tbl[10] = '{50, 1,  1, 19, 23, 12, 2,  1, 16, 20, 1, 0};
        tbl[11] = '{80, 0,  1, 6,  7,  0,  4,  1, 0,  1,  1, 0};
        tbl[12] = '{92, 0,  1, 30, 31, 0,  4,  1, 24, 25, 1, 0};
        tbl[13] = '{95, 0,  0, -1, -1, -1, -1, 1, 30, 31, 1, 0};
        tbl[14] = '{96, 0,  0, -1, -1, -1, -1, 0, -1, -1, 0, 1};
        tbl[15] = '{97, 0,  0, -1, -1, -1, -1, 0, -1, -1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        rst = 1'b0;

        // Run 1: timing table, with stray start pulses at cycles 10 and 50.
        begin_xfer();
        for (int i = 0; i < 16; i++) begin
            while (cycle() < tbl[i].cyc) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
            chk_dc($sformatf("v%0d_rd_en", i), int'(bus.rd_en), tbl[i].rd);
            chk_dc($sformatf("v%0d_rd_a", i), int'(bus.rd_addr_a), tbl[i].ra);
            chk_dc($sformatf("v%0d_rd_b", i), int'(bus.rd_addr_b), tbl[i].rb);
            chk_dc($sformatf("v%0d_tw", i), int'(bus.tw_idx), tbl[i].tw);
            chk_dc($sformatf("v%0d_stage", i), int'(bus.stage), tbl[i].st);
            chk_dc($sformatf("v%0d_wr_en", i), int'(bus.wr_en), tbl[i].wr);
            chk_dc($sformatf("v%0d_wr_a", i), int'(bus.wr_addr_a), tbl[i].wa);
            chk_dc($sformatf("v%0d_wr_b", i), int'(bus.wr_addr_b), tbl[i].wb);
            chk_dc($sformatf("v%0d_busy", i), int'(bus.busy), tbl[i].busy);
            chk_dc($sformatf("v%0d_done", i), int'(bus.done), tbl[i].done);
            bus.start = (tbl[i].start != 0);
        end
        bus.start = 1'b0;
        end_xfer(96);

        // Run 2: reset at cycle 40 while stage 2 is issuing and writes are in flight.
        begin_xfer();
        while (cycle() < 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mon_on = 1'b0;
        chk("midrst_rd_en", int'(bus.rd_en), 0);
        chk("midrst_wr_en", int'(bus.wr_en), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_stage", int'(bus.stage), 0);
        chk("midrst_rd_a", int'(bus.rd_addr_a), 0);
        chk("midrst_rd_b", int'(bus.rd_addr_b), 0);
        chk("midrst_tw", int'(bus.tw_idx), 0);
        chk("midrst_wr_a", int'(bus.wr_addr_a), 0);
        chk("midrst_wr_b", int'(bus.wr_addr_b), 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst_wr_en", int'(bus.wr_en), 0);
            chk("postrst_rd_en", int'(bus.rd_en), 0);
        end

        // Run 3: clean restart after the abort.
        begin_xfer();
        end_xfer(96);

`ifdef IFFT_BFLY_SEQ_HOLD_EN
        // Run 4: hold sampled at edges 8..12 and 79..81 (stage-3 flush): 8 stall cycles.
        hold_run = 1'b1;
        begin_xfer();
        while (cycle() < 110) begin
            hold = ((cycle() >= 7) && (cycle() < 12)) || ((cycle() >= 78) && (cycle() < 81));
            @(negedge clk);
        end
        hold = 1'b0;
        end_xfer(104);
        hold_run = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
